// File: rtl/flash_fetch_unit.sv
// Instruction fetcher: issues one flash byte read per cycle, tracks the read latency
// with a tag pipeline and presents the assembled word over a valid/ready handshake.
module flash_fetch_unit #(
    parameter int unsigned ADDR_WIDTH   = 24,
    parameter int unsigned INSTR_BYTES  = 4,
    parameter int unsigned READ_LATENCY = 1,
    parameter bit          BIG_ENDIAN   = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     fetch_req,
    input  logic [ADDR_WIDTH-1:0]    fetch_addr,
    output logic                     fetch_ready,
    input  logic                     fetch_flush,
    output logic                     instr_valid,
    input  logic                     instr_ready,
    output logic [8*INSTR_BYTES-1:0] instr,
    output logic [ADDR_WIDTH-1:0]    instr_addr,
    output logic                     flash_re,
    output logic [ADDR_WIDTH-1:0]    flash_addr,
    input  logic [7:0]               flash_out
);

    localparam int unsigned    KW     = (INSTR_BYTES > 1) ? $clog2(INSTR_BYTES) : 1;
    localparam logic [KW-1:0]  K_LAST = KW'(INSTR_BYTES - 1);

    if (INSTR_BYTES == 0 || INSTR_BYTES > 8 || READ_LATENCY == 0 || READ_LATENCY > 4) begin : g_cfg_error
        $error("flash_fetch_unit: INSTR_BYTES must be 1..8 and READ_LATENCY 1..4");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, HOLD} state_t;

    state_t                  state, state_next;
    logic [ADDR_WIDTH-1:0]   base;
    logic [KW-1:0]           k;
    logic [KW-1:0]           lane;
    logic                    accept, issuing, cap_valid, cap_last;
    logic                    tag_v    [READ_LATENCY];
    logic                    tag_last [READ_LATENCY];
    logic [KW-1:0]           tag_lane [READ_LATENCY];

    assign lane      = BIG_ENDIAN ? (K_LAST - k) : k;
    assign cap_valid = tag_v[READ_LATENCY-1];
    assign cap_last  = cap_valid & tag_last[READ_LATENCY-1];
    assign accept    = fetch_ready & fetch_req & ~fetch_flush;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = ISSUE;
            ISSUE:   if (k == K_LAST) state_next = DRAIN;
            DRAIN:   if (cap_last) state_next = HOLD;
            HOLD: begin
                if (accept)           state_next = ISSUE;
                else if (instr_ready) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (fetch_flush) state_next = IDLE;
    end

    always_comb begin
        issuing     = (state == ISSUE);
        flash_re    = issuing;
        flash_addr  = issuing ? (base + ADDR_WIDTH'(k)) : '0;
        instr_valid = (state == HOLD);
        fetch_ready = (state == IDLE) | ((state == HOLD) & instr_ready);
        instr_addr  = base;
    end

    // Each issued byte carries its lane through a READ_LATENCY-deep tag pipe; the
    // byte is written when its tag reaches the end, so late data after a flush is dropped.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            base  <= '0;
            k     <= '0;
            instr <= '0;
            for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                tag_v[i]    <= 1'b0;
                tag_last[i] <= 1'b0;
                tag_lane[i] <= '0;
            end
        end else begin
            if (fetch_flush) begin
                for (int unsigned i = 0; i < READ_LATENCY; i++) begin
                    tag_v[i]    <= 1'b0;
                    tag_last[i] <= 1'b0;
                end
            end else begin
                tag_v[0]    <= issuing;
                tag_last[0] <= issuing & (k == K_LAST);
                tag_lane[0] <= lane;
                for (int unsigned i = 1; i < READ_LATENCY; i++) begin
                    tag_v[i]    <= tag_v[i-1];
                    tag_last[i] <= tag_last[i-1];
                    tag_lane[i] <= tag_lane[i-1];
                end
                if (cap_valid) instr[{tag_lane[READ_LATENCY-1], 3'b000} +: 8] <= flash_out;
            end

            if (accept) begin
                base  <= fetch_addr;
                k     <= '0;
                instr <= '0;
            end else if (issuing && !fetch_flush) begin
                k <= k + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flash_fetch_unit.sv
// Scoreboard bench for flash_fetch_unit: default, little-endian and latency-2 instances
// share stimulus, each with its own flash model.
module tb_flash_fetch_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req = 1'b0;
    logic        fetch_flush = 1'b0;
    logic        instr_ready = 1'b0;
    logic [23:0] fetch_addr = '0;

    logic [2:0]  fready_o, valid_o, re_o;
    logic [31:0] instr_o [3];
    logic [23:0] iaddr_o [3];
    logic [23:0] faddr_o [3];
    logic [7:0]  fo [3];
    logic [7:0]  p2;

    logic [7:0] mem [16] = '{8'h93, 8'h00, 8'hA1, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44,
                             8'h55, 8'h66, 8'h77, 8'h88, 8'h99, 8'hAA, 8'h5A, 8'hC3};

    typedef struct {
        logic [31:0] word;
        logic [23:0] addr;
    } exp_t;
    exp_t exp_q [$];

    int n_tests = 0;
    int n_fail  = 0;

    int          lat_r [3];
    logic [31:0] w_r [3];
    logic [23:0] ia_r;
    int          nre_r;
    logic [23:0] ra_r [8];

    always #5 clk = ~clk;

    flash_fetch_unit u_dut (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fready_o[0]), .fetch_flush(fetch_flush), .instr_valid(valid_o[0]),
        .instr_ready(instr_ready), .instr(instr_o[0]), .instr_addr(iaddr_o[0]),
        .flash_re(re_o[0]), .flash_addr(faddr_o[0]), .flash_out(fo[0])
    );

    flash_fetch_unit #(.BIG_ENDIAN(1'b0)) u_le (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fready_o[1]), .fetch_flush(fetch_flush), .instr_valid(valid_o[1]),
        .instr_ready(instr_ready), .instr(instr_o[1]), .instr_addr(iaddr_o[1]),
        .flash_re(re_o[1]), .flash_addr(faddr_o[1]), .flash_out(fo[1])
    );

    flash_fetch_unit #(.READ_LATENCY(2)) u_rl2 (
        .clk(clk), .reset(reset), .fetch_req(fetch_req), .fetch_addr(fetch_addr),
        .fetch_ready(fready_o[2]), .fetch_flush(fetch_flush), .instr_valid(valid_o[2]),
        .instr_ready(instr_ready), .instr(instr_o[2]), .instr_addr(iaddr_o[2]),
        .flash_re(re_o[2]), .flash_addr(faddr_o[2]), .flash_out(fo[2])
    );

    // Flash models; 8'hEE marks cycles without a read so stray captures show up.
    always @(posedge clk) begin
        fo[0] <= re_o[0] ? mem[faddr_o[0][3:0]] : 8'hEE;
        fo[1] <= re_o[1] ? mem[faddr_o[1][3:0]] : 8'hEE;
        p2    <= re_o[2] ? mem[faddr_o[2][3:0]] : 8'hEE;
        fo[2] <= p2;
    end

    function automatic logic [31:0] model_word(input logic [23:0] a, input bit big);
        logic [31:0] w;
        logic [23:0] ak;
        w = '0;
        for (int k = 0; k < 4; k++) begin
            ak = a + 24'(k);
            if (big) w[(3-k)*8 +: 8] = mem[ak[3:0]];
            else     w[k*8 +: 8]     = mem[ak[3:0]];
        end
        return w;
    endfunction

    task automatic do_reset;
        fetch_req = 1'b0; fetch_flush = 1'b0; instr_ready = 1'b0; fetch_addr = '0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic push_exp(input logic [23:0] a);
        exp_t e;
        e.word = model_word(a, 1'b1);
        e.addr = a;
        exp_q.push_back(e);
    endtask

    // One fetch with instr_ready held high; records issue addresses and per-instance latency.
    task automatic fetch_all(input logic [23:0] a);
        for (int i = 0; i < 3; i++) begin lat_r[i] = 0; w_r[i] = '0; end
        nre_r = 0; ia_r = '0;
        @(negedge clk);
        fetch_addr = a; fetch_req = 1'b1; instr_ready = 1'b1;
        push_exp(a);
        @(posedge clk); #1 fetch_req = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            if (re_o[0]) begin
                if (nre_r < 8) ra_r[nre_r] = faddr_o[0];
                nre_r++;
            end
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (valid_o[i] && lat_r[i] == 0) begin
                    lat_r[i] = n;
                    w_r[i] = instr_o[i];
                    if (i == 0) ia_r = iaddr_o[0];
                end
            end
            if (lat_r[0] != 0 && lat_r[1] != 0 && lat_r[2] != 0) break;
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (fready_o[0] !== 1'b1) begin n_fail++; $display("FAIL reset_fetch_ready: got %b expected 1", fready_o[0]); end
        n_tests++; if (valid_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_instr_valid: got %b expected 0", valid_o[0]); end
        n_tests++; if (re_o[0] !== 1'b0) begin n_fail++; $display("FAIL reset_flash_re: got %b expected 0", re_o[0]); end
        n_tests++; if (faddr_o[0] !== 24'h0) begin n_fail++; $display("FAIL reset_flash_addr: got %h expected 000000", faddr_o[0]); end
        n_tests++; if (instr_o[0] !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h expected 00000000", instr_o[0]); end
        n_tests++; if (iaddr_o[0] !== 24'h0) begin n_fail++; $display("FAIL reset_instr_addr: got %h expected 000000", iaddr_o[0]); end
        reset = 1'b0;
    endtask

    task automatic test_basic;
        exp_t e;
        do_reset();
        fetch_all(24'h0);
        n_tests++; if (nre_r != 4) begin n_fail++; $display("FAIL basic_re_cycles: got %0d expected 4", nre_r); end
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (ra_r[k] !== 24'(k)) begin n_fail++; $display("FAIL basic_flash_addr[%0d]: got %h expected %h", k, ra_r[k], 24'(k)); end
        end
        n_tests++; if (lat_r[0] != 5) begin n_fail++; $display("FAIL basic_latency: got %0d expected 5", lat_r[0]); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL basic_scoreboard: got empty queue expected one entry"); end
        else begin
            e = exp_q.pop_front();
            if (w_r[0] !== e.word || ia_r !== e.addr) begin
                n_fail++; $display("FAIL basic_word: got %h@%h expected %h@%h", w_r[0], ia_r, e.word, e.addr);
            end
        end
        n_tests++; if (w_r[0] !== 32'h9300A100) begin n_fail++; $display("FAIL basic_word_const: got %h expected 9300a100", w_r[0]); end
    endtask

    task automatic test_endian;
        exp_t e;
        do_reset();
        fetch_all(24'h0);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n_tests++; if (w_r[1] !== 32'h00A10093) begin n_fail++; $display("FAIL endian_word: got %h expected 00a10093", w_r[1]); end
        n_tests++; if (lat_r[1] != 5) begin n_fail++; $display("FAIL endian_latency: got %0d expected 5", lat_r[1]); end
    endtask

    task automatic test_latency;
        exp_t e;
        do_reset();
        fetch_all(24'h0);
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n_tests++; if (lat_r[2] != 6) begin n_fail++; $display("FAIL rl2_latency: got %0d expected 6", lat_r[2]); end
        n_tests++; if (w_r[2] !== 32'h9300A100) begin n_fail++; $display("FAIL rl2_word: got %h expected 9300a100", w_r[2]); end
    endtask

    task automatic test_backpressure;
        exp_t e;
        logic [31:0] hw;
        logic [23:0] ha;
        bit seen;
        do_reset();
        @(negedge clk);
        fetch_addr = 24'h4; fetch_req = 1'b1; instr_ready = 1'b0;
        push_exp(24'h4);
        @(posedge clk); #1 fetch_req = 1'b0;
        for (int n = 0; n < 20 && !valid_o[0]; n++) begin @(posedge clk); #1; end
        n_tests++; if (valid_o[0] !== 1'b1) begin n_fail++; $display("FAIL bp_valid_timeout: got %b expected 1", valid_o[0]); end
        hw = instr_o[0]; ha = iaddr_o[0];
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            fetch_req = (c != 1); fetch_addr = 24'h8;
            @(posedge clk); #1;
            n_tests++;
            if (valid_o[0] !== 1'b1 || instr_o[0] !== hw || iaddr_o[0] !== ha) begin
                n_fail++; $display("FAIL bp_stable[%0d]: got v=%b %h@%h expected v=1 %h@%h", c, valid_o[0], instr_o[0], iaddr_o[0], hw, ha);
            end
        end
        @(negedge clk);
        fetch_req = 1'b0; instr_ready = 1'b1;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL bp_scoreboard: got empty queue expected one entry"); end
        else begin
            e = exp_q.pop_front();
            if (hw !== e.word || ha !== e.addr) begin n_fail++; $display("FAIL bp_word: got %h@%h expected %h@%h", hw, ha, e.word, e.addr); end
        end
        @(posedge clk); #1;
        n_tests++; if (valid_o[0] !== 1'b0 || fready_o[0] !== 1'b1) begin n_fail++; $display("FAIL bp_complete: got v=%b rdy=%b expected v=0 rdy=1", valid_o[0], fready_o[0]); end
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (re_o[0]) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL bp_req_queued: got flash_re=1 expected 0"); end
        instr_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        exp_t e;
        logic [31:0] w1;
        logic [23:0] a1;
        int lat;
        do_reset();
        @(negedge clk);
        fetch_addr = 24'h0; fetch_req = 1'b1; instr_ready = 1'b0;
        push_exp(24'h0);
        @(posedge clk); #1 fetch_req = 1'b0;
        for (int n = 0; n < 20 && !valid_o[0]; n++) begin @(posedge clk); #1; end
        n_tests++; if (valid_o[0] !== 1'b1) begin n_fail++; $display("FAIL b2b_first_timeout: got %b expected 1", valid_o[0]); end
        @(negedge clk);
        w1 = instr_o[0]; a1 = iaddr_o[0];
        instr_ready = 1'b1; fetch_req = 1'b1; fetch_addr = 24'h4;
        push_exp(24'h4);
        @(posedge clk); #1 fetch_req = 1'b0;
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_scoreboard1: got empty queue expected entry"); end
        else begin
            e = exp_q.pop_front();
            if (w1 !== e.word || a1 !== e.addr) begin n_fail++; $display("FAIL b2b_word1: got %h@%h expected %h@%h", w1, a1, e.word, e.addr); end
        end
        n_tests++;
        if (valid_o[0] !== 1'b0 || re_o[0] !== 1'b1 || faddr_o[0] !== 24'h4) begin
            n_fail++; $display("FAIL b2b_issue: got v=%b re=%b addr=%h expected v=0 re=1 addr=000004", valid_o[0], re_o[0], faddr_o[0]);
        end
        lat = 0;
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (valid_o[0]) begin lat = n; break; end
        end
        n_tests++; if (lat != 5) begin n_fail++; $display("FAIL b2b_latency: got %0d expected 5", lat); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL b2b_scoreboard2: got empty queue expected entry"); end
        else begin
            e = exp_q.pop_front();
            if (instr_o[0] !== e.word || iaddr_o[0] !== e.addr) begin
                n_fail++; $display("FAIL b2b_word2: got %h@%h expected %h@%h", instr_o[0], iaddr_o[0], e.word, e.addr);
            end
        end
        repeat (3) @(negedge clk);
        instr_ready = 1'b0;
    endtask

    task automatic test_wrap;
        exp_t e;
        logic [23:0] exp_a [4] = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000, 24'h000001};
        do_reset();
        fetch_all(24'hFFFFFE);
        for (int k = 0; k < 4; k++) begin
            n_tests++;
            if (ra_r[k] !== exp_a[k]) begin n_fail++; $display("FAIL wrap_flash_addr[%0d]: got %h expected %h", k, ra_r[k], exp_a[k]); end
        end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL wrap_scoreboard: got empty queue expected entry"); end
        else begin
            e = exp_q.pop_front();
            if (w_r[0] !== e.word || ia_r !== e.addr) begin n_fail++; $display("FAIL wrap_word: got %h@%h expected %h@%h", w_r[0], ia_r, e.word, e.addr); end
        end
        n_tests++; if (w_r[0] !== 32'h5AC39300) begin n_fail++; $display("FAIL wrap_word_const: got %h expected 5ac39300", w_r[0]); end
    endtask

    task automatic test_flush;
        exp_t e;
        bit seen;
        do_reset();
        @(negedge clk);
        fetch_addr = 24'h0; fetch_req = 1'b1; instr_ready = 1'b1;
        @(posedge clk); #1 fetch_req = 1'b0;
        @(posedge clk); #1;
        n_tests++; if (re_o[0] !== 1'b1) begin n_fail++; $display("FAIL flush_pre_issue: got re=%b expected 1", re_o[0]); end
        fetch_flush = 1'b1;
        @(posedge clk); #1 fetch_flush = 1'b0;
        n_tests++; if (re_o[0] !== 1'b0 || fready_o[0] !== 1'b1) begin n_fail++; $display("FAIL flush_idle: got re=%b rdy=%b expected re=0 rdy=1", re_o[0], fready_o[0]); end
        seen = 1'b0;
        repeat (8) begin @(posedge clk); #1; if (valid_o[0] || re_o[0]) seen = 1'b1; end
        n_tests++; if (seen !== 1'b0) begin n_fail++; $display("FAIL flush_late_data: got valid/re activity expected none"); end

        @(negedge clk);
        fetch_addr = 24'h4; fetch_req = 1'b1; instr_ready = 1'b0;
        @(posedge clk); #1 fetch_req = 1'b0;
        repeat (4) @(posedge clk);
        #3 reset = 1'b1;
        #1;
        n_tests++;
        if (re_o[0] !== 1'b0 || valid_o[0] !== 1'b0 || fready_o[0] !== 1'b1 || faddr_o[0] !== 24'h0) begin
            n_fail++; $display("FAIL async_reset_ctrl: got re=%b v=%b rdy=%b fa=%h expected 0 0 1 000000", re_o[0], valid_o[0], fready_o[0], faddr_o[0]);
        end
        n_tests++;
        if (instr_o[0] !== 32'h0 || iaddr_o[0] !== 24'h0) begin
            n_fail++; $display("FAIL async_reset_data: got %h@%h expected 00000000@000000", instr_o[0], iaddr_o[0]);
        end
        @(negedge clk) reset = 1'b0;
        fetch_all(24'h0);
        n_tests++; if (lat_r[0] != 5) begin n_fail++; $display("FAIL post_reset_latency: got %0d expected 5", lat_r[0]); end
        n_tests++;
        if (exp_q.size() == 0) begin n_fail++; $display("FAIL post_reset_scoreboard: got empty queue expected entry"); end
        else begin
            e = exp_q.pop_front();
            if (w_r[0] !== e.word || ia_r !== e.addr) begin n_fail++; $display("FAIL post_reset_word: got %h@%h expected %h@%h", w_r[0], ia_r, e.word, e.addr); end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_endian();
        test_latency();
        test_backpressure();
        test_back_to_back();
        test_wrap();
        test_flush();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
